// File: rtl/vga_fetch_scheduler.sv
// AXI read sequencer that keeps two display line buffers (ping/pong banks) filled,
// walking the framebuffer in BURST_LEN-beat INCR bursts from base to top and wrapping.
module vga_fetch_scheduler #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int BURST_LEN  = 32,
  parameter int BEAT_BYTES = 8,
  localparam int IDX_W     = $clog2(BURST_LEN)
) (
  input  logic                  clk_a,
  input  logic                  reset_a,
  input  logic                  enable_i,
  input  logic                  frame_restart_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH-1:0] top_addr_i,
  input  logic [1:0]            bank_free_i,
  output logic [1:0]            bank_full_o,
  output logic                  wr_en_o,
  output logic                  wr_bank_o,
  output logic [IDX_W-1:0]      wr_idx_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic [ADDR_WIDTH-1:0] araddr_o,
  output logic [1:0]            arburst_o,
  output logic [7:0]            arlen_o,
  output logic [2:0]            arsize_o,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  input  logic                  rvalid_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]            rresp_i,
  input  logic                  rlast_i,
  output logic                  rready_o,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam logic [ADDR_WIDTH:0] BURST_BYTES = (ADDR_WIDTH+1)'(BURST_LEN * BEAT_BYTES);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, COMMIT} state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   cur_addr_reg;
  logic [ADDR_WIDTH-1:0]   araddr_reg;
  logic                    fill_bank_reg;
  logic [IDX_W-1:0]        beat_cnt_reg;
  logic                    restart_pend_reg;
  logic [1:0]              bank_full_reg, bank_full_next;
  logic                    wr_en_reg, wr_bank_reg;
  logic [IDX_W-1:0]        wr_idx_reg;
  logic [DATA_WIDTH-1:0]   wr_data_reg;
  logic                    err_reg;

  logic                    beat, last_beat, restart_now, commit_ok, wrap;
  logic [ADDR_WIDTH:0]     addr_sum;

  assign beat        = (state_reg == DATA) && rvalid_i;
  assign last_beat   = (beat_cnt_reg == IDX_W'(BURST_LEN - 1));
  assign restart_now = (state_reg == IDLE) && (restart_pend_reg || frame_restart_i);
  assign commit_ok   = (state_reg == COMMIT) && !restart_pend_reg;

  // The extra top bit catches address overflow, which counts as reaching top.
  assign addr_sum = {1'b0, cur_addr_reg} + BURST_BYTES;
  assign wrap     = addr_sum[ADDR_WIDTH] || (addr_sum[ADDR_WIDTH-1:0] >= top_addr_i);

  // Priority per bank: restart clear, then commit set, then reader release.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    assign bank_full_next[gi] = restart_now ? 1'b0 :
        ((commit_ok && (fill_bank_reg == 1'(gi))) || (bank_full_reg[gi] && !bank_free_i[gi]));
  end

  always_ff @(posedge clk_a) begin
    if (reset_a) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (!(restart_pend_reg || frame_restart_i) && enable_i &&
                   !bank_full_reg[fill_bank_reg])
                 state_next = ADDR;
      ADDR:    if (arready_i) state_next = DATA;
      DATA:    if (beat && last_beat) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_a) begin
    if (reset_a) begin
      cur_addr_reg     <= base_addr_i;
      araddr_reg       <= '0;
      fill_bank_reg    <= 1'b0;
      beat_cnt_reg     <= '0;
      restart_pend_reg <= 1'b0;
      bank_full_reg    <= '0;
      wr_en_reg        <= 1'b0;
      wr_bank_reg      <= 1'b0;
      wr_idx_reg       <= '0;
      wr_data_reg      <= '0;
      err_reg          <= 1'b0;
    end else begin
      bank_full_reg <= bank_full_next;
      wr_en_reg     <= beat;

      if (restart_now)
        restart_pend_reg <= 1'b0;
      else if (state_reg != IDLE && frame_restart_i)
        restart_pend_reg <= 1'b1;

      if (restart_now) begin
        cur_addr_reg  <= base_addr_i;
        fill_bank_reg <= 1'b0;
      end else if (state_reg == IDLE && state_next == ADDR) begin
        araddr_reg <= cur_addr_reg;
      end

      if (state_reg == ADDR && arready_i)
        beat_cnt_reg <= '0;

      if (beat) begin
        wr_bank_reg  <= fill_bank_reg;
        wr_idx_reg   <= beat_cnt_reg;
        wr_data_reg  <= (rresp_i == 2'b00) ? rdata_i : '0;
        beat_cnt_reg <= beat_cnt_reg + IDX_W'(1);
        // Length is fixed by counting; a misplaced rlast is only reported.
        if (rresp_i != 2'b00 || rlast_i != last_beat)
          err_reg <= 1'b1;
      end

      if (commit_ok) begin
        fill_bank_reg <= ~fill_bank_reg;
        cur_addr_reg  <= wrap ? base_addr_i : addr_sum[ADDR_WIDTH-1:0];
      end
    end
  end

  assign bank_full_o = bank_full_reg;
  assign wr_en_o     = wr_en_reg;
  assign wr_bank_o   = wr_bank_reg;
  assign wr_idx_o    = wr_idx_reg;
  assign wr_data_o   = wr_data_reg;
  assign araddr_o    = araddr_reg;
  assign arburst_o   = 2'b01;
  assign arlen_o     = 8'(BURST_LEN - 1);
  assign arsize_o    = 3'($clog2(BEAT_BYTES));
  assign arvalid_o   = (state_reg == ADDR);
  assign rready_o    = (state_reg == DATA);
  assign busy_o      = (state_reg != IDLE);
  assign err_o       = err_reg;

endmodule

// File: tb/tb_vga_fetch_scheduler.sv
// Directed bench for vga_fetch_scheduler: a small AXI read slave plus a buffer-write
// monitor, driven through fill, wrap, AR stall, frame restart, error and enable scenarios.
module tb_vga_fetch_scheduler;
  localparam int AW = 64, DW = 64, BL = 32, BB = 8, IW = $clog2(BL);

  logic          clk_a = 1'b0;
  logic          reset_a = 1'b1, enable_i = 1'b0, frame_restart_i = 1'b0;
  logic [AW-1:0] base_addr_i = 64'h1000, top_addr_i = 64'h1200;
  logic [1:0]    bank_free_i = 2'b00;
  logic [1:0]    bank_full_o;
  logic          wr_en_o, wr_bank_o;
  logic [IW-1:0] wr_idx_o;
  logic [DW-1:0] wr_data_o;
  logic [AW-1:0] araddr_o;
  logic [1:0]    arburst_o;
  logic [7:0]    arlen_o;
  logic [2:0]    arsize_o;
  logic          arvalid_o, rready_o, busy_o, err_o;
  logic          arready_i = 1'b0, rvalid_i = 1'b0, rlast_i = 1'b0;
  logic [DW-1:0] rdata_i = '0;
  logic [1:0]    rresp_i = 2'b00;

  always #5 clk_a = ~clk_a;

  vga_fetch_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL), .BEAT_BYTES(BB)) dut (
    .clk_a(clk_a), .reset_a(reset_a), .enable_i(enable_i), .frame_restart_i(frame_restart_i),
    .base_addr_i(base_addr_i), .top_addr_i(top_addr_i), .bank_free_i(bank_free_i),
    .bank_full_o(bank_full_o), .wr_en_o(wr_en_o), .wr_bank_o(wr_bank_o), .wr_idx_o(wr_idx_o),
    .wr_data_o(wr_data_o), .araddr_o(araddr_o), .arburst_o(arburst_o), .arlen_o(arlen_o),
    .arsize_o(arsize_o), .arvalid_o(arvalid_o), .arready_i(arready_i), .rvalid_i(rvalid_i),
    .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i), .rready_o(rready_o),
    .busy_o(busy_o), .err_o(err_o));

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pat(input logic [63:0] a, input int b);
    return 64'hDEAD_0000_0000_0000 ^ (a << 8) ^ 64'(b);
  endfunction

  // Slave / monitor state
  logic [63:0] ar_q[$];
  bit          bursting = 0, ar_pend = 0, r_pend = 0, inj = 0, ar_unstable = 0;
  int          s_beat = 0, ar_wait = 0, ar_delay = 0, stall_cnt = 0;
  logic [63:0] s_addr = '0, stall_addr = '0;
  int          wr_cnt[2] = '{0, 0};
  int          wr_seq[2] = '{0, 0};
  int          idx_err = 0, data_err = 0;
  logic [63:0] data5[2];

  // Transfers are accounted one negedge after the posedge they happened on.
  always @(negedge clk_a) begin
    if (reset_a) begin
      bursting = 0; ar_pend = 0; r_pend = 0; ar_wait = 0;
      arready_i = 1'b0; rvalid_i = 1'b0; rlast_i = 1'b0; rresp_i = 2'b00;
    end else begin
      if (ar_pend) begin bursting = 1; s_beat = 0; s_addr = ar_q[$]; ar_wait = 0; end
      if (r_pend) begin s_beat++; if (s_beat == BL) bursting = 0; end
      if (wr_en_o) begin
        automatic int b = int'(wr_bank_o);
        automatic logic [63:0] exp = (inj && wr_idx_o == 5) ? 64'h0 : pat(ar_q[$], int'(wr_idx_o));
        if (int'(wr_idx_o) != wr_seq[b] % BL) idx_err++;
        if (wr_data_o !== exp) data_err++;
        if (wr_idx_o == 5) data5[b] = wr_data_o;
        wr_cnt[b]++; wr_seq[b]++;
      end
      arready_i = arvalid_o && (ar_wait >= ar_delay);
      if (arvalid_o) begin
        if (ar_wait == 0) stall_addr = araddr_o;
        else if (araddr_o !== stall_addr) ar_unstable = 1;
        if (!arready_i) begin ar_wait++; stall_cnt++; end
      end
      ar_pend = arvalid_o && arready_i;
      if (ar_pend) ar_q.push_back(araddr_o);
      rvalid_i = bursting;
      rdata_i  = pat(s_addr, s_beat);
      rresp_i  = (inj && s_beat == 5) ? 2'b10 : 2'b00;
      rlast_i  = inj ? (s_beat == 30) : (s_beat == BL - 1);
      r_pend   = rvalid_i && rready_o;
    end
  end

  task automatic tick();
    @(negedge clk_a); #1;
  endtask

  task automatic pulse_free(input logic [1:0] v);
    bank_free_i = v; tick(); bank_free_i = 2'b00;
  endtask

  task automatic wait_full(input logic [1:0] want, input string tag);
    int n = 0;
    while (bank_full_o !== want && n < 300) begin tick(); n++; end
    chk(tag, bank_full_o, want);
  endtask

  task automatic wait_beat(input logic [63:0] addr, input int beat, input string tag);
    int n = 0;
    while (!(bursting && s_addr == addr && s_beat == beat) && n < 300) begin tick(); n++; end
    chk(tag, s_beat, beat);
  endtask

  initial begin
    int n_ar, n;
    repeat (3) tick();
    chk("rst_busy", busy_o, 0);          chk("rst_arvalid", arvalid_o, 0);
    chk("rst_rready", rready_o, 0);      chk("rst_full", bank_full_o, 0);
    chk("rst_wr_en", wr_en_o, 0);        chk("rst_err", err_o, 0);
    chk("rst_araddr", araddr_o, 0);      chk("arburst", arburst_o, 2'b01);
    chk("arlen", arlen_o, 8'd31);        chk("arsize", arsize_o, 3'd3);

    // Fill both banks from reset
    reset_a = 1'b0; enable_i = 1'b1;
    wait_full(2'b11, "fill_both");
    chk("ar_cnt1", ar_q.size(), 2);
    chk("ar0", ar_q[0], 64'h1000);       chk("ar1", ar_q[1], 64'h1100);
    chk("wr_cnt0_a", wr_cnt[0], 32);     chk("wr_cnt1_a", wr_cnt[1], 32);
    chk("idx_seq_a", idx_err, 0);        chk("data_a", data_err, 0);
    repeat (20) tick();
    chk("no_ar_full", ar_q.size(), 2);   chk("idle_busy", busy_o, 0);

    // Release bank 0: address wraps back to base
    pulse_free(2'b01);
    chk("free_clears", bank_full_o, 2'b10);
    wait_full(2'b11, "refill0");
    chk("ar_cnt2", ar_q.size(), 3);      chk("ar2_wrap", ar_q[2], 64'h1000);
    chk("wr_cnt0_b", wr_cnt[0], 64);     chk("data_b", data_err, 0);

    // AR stall of 5 cycles
    ar_delay = 5; stall_cnt = 0; ar_unstable = 0;
    pulse_free(2'b10);
    wait_full(2'b11, "refill1_stall");
    ar_delay = 0;
    chk("ar_cnt3", ar_q.size(), 4);      chk("ar3", ar_q[3], 64'h1100);
    chk("stall_cycles", stall_cnt, 5);   chk("ar_stable", ar_unstable, 0);

    // Frame restart at beat 10 of the 0x1100 burst
    pulse_free(2'b11);
    wait_beat(64'h1100, 10, "reach_beat10");
    frame_restart_i = 1'b1; tick(); frame_restart_i = 1'b0;
    n = 0;
    while (ar_q.size() < 7 && n < 300) begin tick(); n++; end
    chk("ar_cnt_rst", ar_q.size(), 7);
    chk("ar_after_rst", ar_q[6], 64'h1000);
    chk("full_after_rst", bank_full_o, 2'b00);
    chk("drained_beats", wr_cnt[1], 96);
    wait_full(2'b01, "rst_fill_bank0");
    wait_full(2'b11, "rst_fill_bank1");
    chk("ar7", ar_q[7], 64'h1100);
    chk("idx_seq_c", idx_err, 0);        chk("data_c", data_err, 0);

    // Error response at beat 5, early rlast at beat 30
    chk("err_clear", err_o, 0);
    inj = 1;
    pulse_free(2'b01);
    wait_full(2'b11, "err_fill");
    inj = 0;
    chk("err_set", err_o, 1);            chk("err_data5", data5[0], 0);
    chk("err_beats", wr_cnt[0], 160);    chk("data_d", data_err, 0);
    chk("ar8", ar_q[8], 64'h1000);

    // Enable dropped mid-burst
    pulse_free(2'b11);
    wait_beat(64'h1100, 3, "reach_beat3");
    enable_i = 1'b0;
    n_ar = ar_q.size();
    wait_full(2'b10, "dis_commit");
    repeat (30) tick();
    chk("dis_no_ar", ar_q.size(), n_ar);
    chk("dis_arvalid", arvalid_o, 0);    chk("dis_busy", busy_o, 0);
    enable_i = 1'b1;
    wait_full(2'b11, "reenable_fill");
    chk("ar_reenable", ar_q[$], 64'h1000);
    chk("err_sticky", err_o, 1);
    chk("idx_seq_e", idx_err, 0);

    // Reset clears sticky error and tokens
    reset_a = 1'b1;
    repeat (2) tick();
    chk("rst2_err", err_o, 0);           chk("rst2_full", bank_full_o, 0);
    chk("rst2_busy", busy_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_fetch_scheduler.md
Name: vga_fetch_scheduler

Overview:
- Single-clock AXI-side sequencer that keeps the VGA ping/pong line buffers filled.
- Issues one 32-beat INCR read burst at a time, walking the framebuffer from base_addr_i up to top_addr_i and then wrapping back to base.
- Steers returned beats into bank 0 or bank 1 by strobe and index, and tracks per-bank full/free tokens with the display-side reader.
- Handles frame restart, AXI response errors and enable gating.

Parameters:
ADDR_WIDTH, 64, AXI address width
DATA_WIDTH, 64, AXI data / buffer word width
BURST_LEN, 32, beats per burst = words per bank (power of two, 2..256)
BEAT_BYTES, 8, bytes per beat (power of two); arsize_o = log2(BEAT_BYTES)

Ports:
clk_a  in  1  AXI-side clock
reset_a  in  1  synchronous, active-high reset
enable_i  in  1  fetching allowed; deassertion lets any in-flight burst finish
frame_restart_i  in  1  one-cycle pulse (vsync): restart at base_addr_i, invalidate both banks
base_addr_i  in  ADDR_WIDTH  framebuffer start (BEAT_BYTES*BURST_LEN aligned)
top_addr_i  in  ADDR_WIDTH  framebuffer end, exclusive
bank_free_i  in  2  per-bank release pulse from reader (already synchronised into clk_a)
bank_full_o  out  2  bank holds a complete burst
wr_en_o  out  1  buffer write strobe
wr_bank_o  out  1  bank being written
wr_idx_o  out  log2(BURST_LEN)  word index within bank
wr_data_o  out  DATA_WIDTH  word to write
araddr_o  out  ADDR_WIDTH  AR address
arburst_o  out  2  constant 2'b01
arlen_o  out  8  constant BURST_LEN-1
arsize_o  out  3  constant log2(BEAT_BYTES)
arvalid_o  out  1  AR valid
arready_i  in  1  AR ready
rvalid_i  in  1  R valid
rdata_i  in  DATA_WIDTH  R data
rresp_i  in  2  R response
rlast_i  in  1  R last
rready_o  out  1  R ready
busy_o  out  1  state != IDLE
err_o  out  1  sticky error flag

Behaviour:
- Reset (reset_a=1 at clk_a edge):
  - state=IDLE; cur_addr<=base_addr_i; fill_bank<=0; beat_cnt<=0; restart_pend<=0.
  - All outputs 0, except constant arburst_o/arlen_o/arsize_o.
- Registered outputs: arvalid_o = (state==ADDR); rready_o = (state==DATA); busy_o = (state!=IDLE).
- IDLE:
  - If restart_pend or frame_restart_i: cur_addr<=base_addr_i, bank_full_o<=0, fill_bank<=0, clear pend; stay IDLE that cycle.
  - Else if enable_i and !bank_full_o[fill_bank]: araddr_o<=cur_addr; go to ADDR. arvalid_o is high the next cycle.
- ADDR: hold araddr_o and arvalid_o stable until arready_i. On handshake go to DATA with beat_cnt=0.
- DATA:
  - Each rvalid_i&rready_o beat: next cycle wr_en_o=1, wr_bank_o=fill_bank, wr_idx_o=beat_cnt, wr_data_o = rresp_i==0 ? rdata_i : 0. Increment beat_cnt.
  - Nonzero rresp sets err_o. rlast_i != (beat_cnt==BURST_LEN-1) sets err_o.
  - Beat counting ignores rlast_i; exactly BURST_LEN beats are accepted.
  - After the final beat, go to COMMIT.
- COMMIT (1 cycle):
  - If restart_pend: discard the bank (not marked full) and return to IDLE, where the restart is applied.
  - Else: bank_full_o[fill_bank]<=1; fill_bank<=~fill_bank; next=cur_addr+BURST_LEN*BEAT_BYTES; cur_addr <= (next>=top_addr_i) ? base_addr_i : next; go to IDLE.
  - Addition is ADDR_WIDTH wide; carry out is treated as >=top.
- frame_restart_i seen in ADDR, DATA or COMMIT: set restart_pend. The AXI transaction is never aborted.
- bank_free_i[b]: clears bank_full_o[b] next cycle.
  - A free for a non-full bank is ignored.
  - Free and set of the same bank in the same cycle cannot occur, because set only targets an empty bank. If forced, set wins.
  - frame_restart clear has priority over set.
- enable_i low: no new AR is issued. A burst already in ADDR or DATA completes and commits.
- Throughput: at most one burst outstanding. Minimum IDLE->IDLE is BURST_LEN+3 cycles with arready and rvalid held high.
- err_o clears only on reset_a.
- reset_a mid-burst: return to IDLE immediately. The downstream AXI slave must also be reset.

Test Plan:
- Reset, base=0x1000, top=0x1200, enable=1, arready/rvalid always 1, no frees → AR at 0x1000 then 0x1100; bank_full_o=2'b11; then no AR; 32 wr_en pulses per bank with idx 0..31.
- Free bank0 after both full → next AR is 0x1000 (wrap, since 0x1200>=top); fills bank0; bank_full_o returns to 2'b11.
- arready delayed 5 cycles → araddr_o/arvalid_o stable across the stall; exactly one AR handshake.
- frame_restart pulse at beat 10 of a burst targeting 0x1100 → burst drains 32 beats, bank not marked full, bank_full_o=0, next AR at 0x1000 into bank0.
- rresp=2'b10 on beat 5 and rlast at beat 30 → wr_data_o=0 at idx 5; err_o=1 and sticky; 32 beats still accepted.
- enable_i dropped during DATA → current burst commits; no further arvalid_o until enable_i returns.
